// File: rtl/alu_txn_pkg.sv
// Shared types and constants for the ALU transaction driver.
// The opcode encoding matches the ECO'd 8-bit ALU netlist.
package alu_txn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OPW   = 2;
    localparam int DEF_TAGW  = 4;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Saturating increment used by the overflow statistic.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/alu_txn_driver_stats.sv
// Transaction statistics: completed-response count (wrapping) and
// overflowing-response count (saturating), both updated on the response handshake.
module alu_txn_stats
    import alu_txn_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs_i,
    input  logic        ovf_i,
    output logic [15:0] txn_count_o,
    output logic [15:0] ovf_count_o
);

    logic [15:0] txn_q, txn_d;
    logic [15:0] ovf_q, ovf_d;

    always_comb begin
        txn_d = txn_q + 16'd1;
        ovf_d = ovf_i ? sat_inc16(ovf_q) : ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_q <= '0;
            ovf_q <= '0;
        end else if (hs_i) begin
            txn_q <= txn_d;
            ovf_q <= ovf_d;
        end
    end

    assign txn_count_o = txn_q;
    assign ovf_count_o = ovf_q;

endmodule

// File: rtl/alu_txn_driver.sv
// Single-outstanding requester for the combinational ALU: registers operands,
// waits SETTLE cycles, captures the result and returns a tagged response.
module alu_txn_driver
    import alu_txn_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int OPW    = DEF_OPW,
    parameter int TAGW   = DEF_TAGW,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [TAGW-1:0]  cmd_tag,
    input  logic             cmd_chk,
    input  logic [WIDTH-1:0] cmd_exp_y,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_overflow,
    output logic [TAGW-1:0]  rsp_tag,
    output logic             rsp_mismatch,
    output logic [15:0]      txn_count,
    output logic [15:0]      ovf_count
);

    if (SETTLE < 1) begin : g_bad_settle
        $error("alu_txn_driver: SETTLE must be >= 1");
    end

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic              cmd_ready_q;
    logic [WIDTH-1:0]  alu_a_q, alu_b_q;
    logic [OPW-1:0]    alu_op_q;
    logic [TAGW-1:0]   tag_q;
    logic              chk_q;
    logic [WIDTH-1:0]  exp_q;
    logic              rsp_valid_q;
    logic [WIDTH-1:0]  rsp_y_q;
    logic              rsp_ovf_q;
    logic [TAGW-1:0]   rsp_tag_q;
    logic              rsp_mm_q;
    logic              rsp_hs;

    assign rsp_hs = rsp_valid_q & rsp_ready;

    // cmd_ready is a registered copy of "in IDLE", so acceptance can never
    // coincide with the RESP->IDLE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tag_q       <= '0;
            chk_q       <= 1'b0;
            exp_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_mm_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        alu_a_q     <= cmd_a;
                        alu_b_q     <= cmd_b;
                        alu_op_q    <= cmd_op;
                        tag_q       <= cmd_tag;
                        chk_q       <= cmd_chk;
                        exp_q       <= cmd_exp_y;
                        cnt_q       <= CNT_LOAD;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_y_q     <= alu_y;
                        rsp_ovf_q   <= alu_overflow;
                        rsp_tag_q   <= tag_q;
                        rsp_mm_q    <= chk_q && (alu_y != exp_q);
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    alu_txn_stats u_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .hs_i        (rsp_hs),
        .ovf_i       (rsp_ovf_q),
        .txn_count_o (txn_count),
        .ovf_count_o (ovf_count)
    );

    assign cmd_ready    = cmd_ready_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_y        = rsp_y_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_tag      = rsp_tag_q;
    assign rsp_mismatch = rsp_mm_q;

endmodule

// File: tb/tb_alu_txn_driver.sv
// Scoreboard bench: instance 0 (SETTLE=1) drives a behavioural ALU, instance 1
// (SETTLE=3) sees a result that changes one cycle after operand drive.
module tb_alu_txn_driver;
    import alu_txn_pkg::*;

    typedef struct packed {
        logic [7:0] y;
        logic       ovf;
        logic [3:0] tag;
        logic       mm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]        cmd_valid, cmd_ready, cmd_chk;
    logic [1:0][7:0]   cmd_a, cmd_b, cmd_exp_y, alu_a, alu_b, alu_y, rsp_y;
    logic [1:0][1:0]   cmd_op, alu_op;
    logic [1:0][3:0]   cmd_tag, rsp_tag;
    logic [1:0]        alu_ovf, rsp_valid, rsp_ready, rsp_overflow, rsp_mismatch;
    logic [1:0][15:0]  txn_count, ovf_count;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [15:0] m_txn [2];
    logic [15:0] m_ovf [2];
    logic [3:0]  age3;

    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] op);
        logic [7:0] y;
        logic v;
        case (op)
            2'd0: begin y = a + b; v = (a[7] == b[7]) && (y[7] != a[7]); end
            2'd1: begin y = a - b; v = (a[7] != b[7]) && (y[7] != a[7]); end
            2'd2: begin y = a & b; v = 1'b0; end
            default: begin y = a | b; v = 1'b0; end
        endcase
        return {v, y};
    endfunction

    assign {alu_ovf[0], alu_y[0]} = alu_model(alu_a[0], alu_b[0], alu_op[0]);
    assign alu_y[1]   = (age3 == 4'd0) ? 8'h11 : 8'h22;
    assign alu_ovf[1] = 1'b0;

    always @(posedge clk) begin
        if (cmd_valid[1] && cmd_ready[1]) age3 <= 4'd0;
        else if (age3 != 4'hF) age3 <= age3 + 4'd1;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_txn_driver #(.WIDTH(8), .OPW(2), .TAGW(4), .SETTLE(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_a(cmd_a[g]), .cmd_b(cmd_b[g]), .cmd_op(cmd_op[g]),
            .cmd_tag(cmd_tag[g]), .cmd_chk(cmd_chk[g]), .cmd_exp_y(cmd_exp_y[g]),
            .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_op(alu_op[g]),
            .alu_y(alu_y[g]), .alu_overflow(alu_ovf[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_y(rsp_y[g]), .rsp_overflow(rsp_overflow[g]),
            .rsp_tag(rsp_tag[g]), .rsp_mismatch(rsp_mismatch[g]),
            .txn_count(txn_count[g]), .ovf_count(ovf_count[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: compare every response at the handshake against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid[d] && rsp_ready[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk("rsp_y",   rsp_y[d], e.y);
                        chk("rsp_ovf", rsp_overflow[d], e.ovf);
                        chk("rsp_tag", rsp_tag[d], e.tag);
                        chk("rsp_mm",  rsp_mismatch[d], e.mm);
                        m_txn[d] = m_txn[d] + 16'd1;
                        if (e.ovf && m_ovf[d] != 16'hFFFF) m_ovf[d] = m_ovf[d] + 16'd1;
                    end
                end
            end
        end
    end

    // Offer a command, wait (bounded) for acceptance, log the expected response.
    task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [3:0] tag, input logic chk_en,
                         input logic [7:0] ey, input logic [7:0] y_e, input logic ovf_e);
        int n;
        exp_t e;
        n = 0;
        cmd_a[d] = a; cmd_b[d] = b; cmd_op[d] = op; cmd_tag[d] = tag;
        cmd_chk[d] = chk_en; cmd_exp_y[d] = ey; cmd_valid[d] = 1'b1;
        while (!cmd_ready[d] && n < 50) begin step(1); n++; end
        if (n >= 50) begin
            chk("accept_timeout", 32'd0, 32'd1);
            cmd_valid[d] = 1'b0;
            return;
        end
        e.y = y_e; e.ovf = ovf_e; e.tag = tag; e.mm = chk_en && (y_e != ey);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        step(1);
        cmd_valid[d] = 1'b0;
        chk("alu_a_drv",  alu_a[d], a);
        chk("alu_b_drv",  alu_b[d], b);
        chk("alu_op_drv", alu_op[d], op);
    endtask

    task automatic wait_rsp(input int d, output int lat);
        lat = 0;
        while (!rsp_valid[d] && lat < 100) begin step(1); lat++; end
        if (lat >= 100) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (!cmd_ready[d] && n < 100) begin step(1); n++; end
        if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run0(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [3:0] tag, input logic chk_en, input logic [7:0] ey,
                        output int lat);
        logic [8:0] m;
        m = alu_model(a, b, op);
        issue(0, a, b, op, tag, chk_en, ey, m[7:0], m[8]);
        wait_rsp(0, lat);
        wait_idle(0);
    endtask

    task automatic check_cnt(input int d);
        chk("txn_count", txn_count[d], m_txn[d]);
        chk("ovf_count", ovf_count[d], m_ovf[d]);
    endtask

    initial begin
        int lat;
        logic [7:0] ra, rb;
        logic [1:0] rop;
        rst_n = 1'b0;
        cmd_valid = '0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        cmd_chk = '0; cmd_exp_y = '0; rsp_ready = 2'b11;
        m_txn[0] = '0; m_txn[1] = '0; m_ovf[0] = '0; m_ovf[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready[0], 1'b1);
        chk("rst_rsp_valid", rsp_valid[0], 1'b0);
        chk("rst_alu_a",     alu_a[0], 8'h00);
        chk("rst_rsp_y",     rsp_y[0], 8'h00);
        chk("rst_txn",       txn_count[0], 16'h0);
        chk("rst_ovf",       ovf_count[0], 16'h0);
        rst_n = 1'b1;
        step(2);

        // Basic add, SETTLE=1
        run0(8'h05, 8'h03, OP_ADD, 4'hA, 1'b0, 8'h00, lat);
        chk("lat_settle1", lat, 1);
        chk("txn_after_1", txn_count[0], 16'd1);

        // Expected-value compare with overflow, match then mismatch
        run0(8'h60, 8'h60, OP_ADD, 4'h3, 1'b1, 8'hC0, lat);
        chk("ovf_after_match", ovf_count[0], 16'd1);
        run0(8'h60, 8'h60, OP_ADD, 4'h4, 1'b1, 8'hC1, lat);
        check_cnt(0);

        // A few random commands across all opcodes
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rop = 2'(i % 4);
            run0(ra, rb, rop, 4'(i), 1'(i % 2), ra ^ rb, lat);
        end
        check_cnt(0);

        // SETTLE=3: result changes mid-window, late value must be captured
        issue(1, 8'h01, 8'h02, OP_ADD, 4'h5, 1'b1, 8'h22, 8'h22, 1'b0);
        chk("settle3_busy", cmd_ready[1], 1'b0);
        wait_rsp(1, lat);
        chk("lat_settle3", lat, 3);
        wait_idle(1);
        check_cnt(1);

        // Back-pressure: response held 5 cycles with a second command waiting
        rsp_ready[0] = 1'b0;
        run0_stall();

        // Counter boundaries: txn wraps, ovf saturates
        g_dut[0].u_dut.u_stats.txn_q = 16'hFFFF;
        g_dut[0].u_dut.u_stats.ovf_q = 16'hFFFF;
        m_txn[0] = 16'hFFFF; m_ovf[0] = 16'hFFFF;
        run0(8'h70, 8'h70, OP_ADD, 4'h9, 1'b0, 8'h00, lat);
        chk("txn_wrap", txn_count[0], 16'h0000);
        chk("ovf_sat",  ovf_count[0], 16'hFFFF);

        // Reset while waiting for the result discards the transaction
        cmd_a[0] = 8'h12; cmd_b[0] = 8'h34; cmd_op[0] = OP_ADD; cmd_tag[0] = 4'h6;
        cmd_valid[0] = 1'b1;
        step(1);
        cmd_valid[0] = 1'b0;
        chk("rst_wait_busy", cmd_ready[0], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid[0], 1'b0);
        chk("midrst_cmd_ready", cmd_ready[0], 1'b1);
        chk("midrst_txn",       txn_count[0], 16'h0);
        chk("midrst_ovf",       ovf_count[0], 16'h0);
        chk("midrst_alu_a",     alu_a[0], 8'h00);
        m_txn[0] = '0; m_ovf[0] = '0; m_txn[1] = '0; m_ovf[1] = '0;
        step(2);
        rst_n = 1'b1;
        step(6);
        chk("midrst_no_rsp", rsp_valid[0], 1'b0);
        chk("midrst_q_empty", q0.size(), 0);
        check_cnt(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic run0_stall();
        int lat;
        logic [8:0] m;
        m = alu_model(8'h21, 8'h10, OP_SUB);
        issue(0, 8'h21, 8'h10, OP_SUB, 4'hB, 1'b0, 8'h00, m[7:0], m[8]);
        wait_rsp(0, lat);
        cmd_a[0] = 8'h44; cmd_b[0] = 8'h0F; cmd_op[0] = OP_AND; cmd_tag[0] = 4'hC;
        cmd_chk[0] = 1'b0; cmd_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall_cmd_ready", cmd_ready[0], 1'b0);
            chk("stall_rsp_valid", rsp_valid[0], 1'b1);
            chk("stall_rsp_y",     rsp_y[0], m[7:0]);
            chk("stall_rsp_tag",   rsp_tag[0], 4'hB);
        end
        rsp_ready[0] = 1'b1;
        step(1);
        chk("post_hs_ready", cmd_ready[0], 1'b1);
        chk("post_hs_alu_a", alu_a[0], 8'h21);
        m = alu_model(8'h44, 8'h0F, OP_AND);
        q0.push_back('{y: m[7:0], ovf: m[8], tag: 4'hC, mm: 1'b0});
        step(1);
        cmd_valid[0] = 1'b0;
        chk("second_accepted", alu_a[0], 8'h44);
        chk("second_busy",     cmd_ready[0], 1'b0);
        wait_rsp(0, lat);
        wait_idle(0);
        check_cnt(0);
    endtask

endmodule

// File: doc/alu_txn_driver.md
# alu_txn_driver

Sequential requester for the 8-bit ECO'd ALU datapath. It accepts operand commands over a valid/ready channel and drives registered `a`/`b`/`op` into the combinational ALU. After a fixed settle window it samples `y` and `overflow`, then returns a tagged response with an optional expected-value check. It sits between the test/processor front end and the ALU netlist, and also keeps transaction and overflow statistics.

## Interface
Parameters:
- `WIDTH`, 8, operand and result width
- `OPW`, 2, opcode width
- `TAGW`, 4, command tag width
- `SETTLE`, 1, cycles between operand drive and result capture; must be ≥1, and 0 is an elaboration error

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_a`, `cmd_b`  in  WIDTH  operands
- `cmd_op`  in  OPW  opcode
- `cmd_tag`  in  TAGW  returned unchanged
- `cmd_chk`  in  1  enable the expected-value compare
- `cmd_exp_y`  in  WIDTH  expected result
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU
- `alu_op`  out  OPW  registered opcode to the ALU
- `alu_y`  in  WIDTH  ALU result
- `alu_overflow`  in  1  ALU overflow
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumed when high with `rsp_valid`
- `rsp_y`  out  WIDTH  captured result
- `rsp_overflow`  out  1  captured overflow
- `rsp_tag`  out  TAGW  tag of the command
- `rsp_mismatch`  out  1  `cmd_chk` was set and `alu_y` ≠ `cmd_exp_y`
- `txn_count`  out  16  completed responses, wraps at 16'hFFFF→0
- `ovf_count`  out  16  responses with overflow, saturates at 16'hFFFF

## Operation
- FSM states and transitions:
  - IDLE: `cmd_ready`=1. On handshake, load `alu_a`/`alu_b`/`alu_op`, latch tag/chk/exp, load settle counter with `SETTLE-1`, and go to WAIT.
  - WAIT: `cmd_ready`=0. The counter decrements each edge. On the edge where the counter is 0, capture `alu_y` and `alu_overflow` into `rsp_*`, compute `rsp_mismatch`, set `rsp_valid`, and go to RESP.
  - RESP: hold all `rsp_*` stable. On `rsp_valid&rsp_ready`, clear `rsp_valid`, increment `txn_count`, increment `ovf_count` if `rsp_overflow` (unless saturated), and go to IDLE.
- `alu_*` hold their last value after capture until the next command, so the ALU outputs stay stable.
- `rsp_y`, `rsp_overflow`, `rsp_tag` and `rsp_mismatch` keep their last values after the handshake and are meaningful only while `rsp_valid` is high.
- Only one transaction is outstanding. `cmd_ready` is low from acceptance until the response handshake completes.
- `rsp_mismatch` is a full WIDTH-bit equality compare, and is 0 when `cmd_chk`=0.
- `cmd_valid` asserted in WAIT or RESP is ignored. No command is lost, because `cmd_ready` is low.
- The RESP→IDLE transition and a new command acceptance never occur in the same cycle. `cmd_ready` rises one cycle after the response handshake.

## Timing
- Reset (async assert, sync deassert expected from the system) sets:
  - all `alu_*`, `rsp_*`, `txn_count` and `ovf_count` to 0
  - `cmd_ready` to 1 (IDLE) and `rsp_valid` to 0
- Command accepted at edge t0: `alu_*` are valid after t0, and `rsp_valid` rises after edge t0+SETTLE.
- `alu_y` is sampled at edge t0+SETTLE, giving the ALU SETTLE full cycles to settle.
- Minimum issue interval is SETTLE+2 cycles: accept, SETTLE wait cycles, response handshake in the first RESP cycle, then one IDLE cycle.
- `rsp_ready` held high makes the handshake complete in the first cycle `rsp_valid` is high.
- Counters update on the response handshake edge and are visible the following cycle.
- Reset mid-transaction discards it: no response is produced and the counters are cleared.

## Structure
- Package `alu_txn_pkg` holds:
  - the state enum (IDLE/WAIT/RESP)
  - opcode constants for the ALU op encoding
  - default `WIDTH`/`TAGW` localparams
- Sub-module `alu_txn_stats` holds the two 16-bit counters (wrap / saturate) and is fed with a handshake strobe and an overflow bit.
- The FSM, settle counter and registers live in the top module.

## Test plan
- Reset release, then `cmd_a`=8'h05, `cmd_b`=8'h03, tag=4'hA, with the bench ALU returning 8'h08, overflow 0 and SETTLE=1 → `rsp_valid` one cycle after acceptance, `rsp_y`=8'h08, `rsp_tag`=4'hA, `txn_count`=1.
- SETTLE=3, with `alu_y` changing from 8'h11 to 8'h22 one cycle after drive → captured value is 8'h22, and `rsp_valid` rises 3 cycles after acceptance.
- `cmd_chk`=1, `cmd_exp_y`=8'hC0, ALU returns 8'hC0 with overflow 1 → `rsp_mismatch`=0, `rsp_overflow`=1, `ovf_count`=1. Repeat with `exp`=8'hC1 → `rsp_mismatch`=1.
- `rsp_ready` held low for 5 cycles while `cmd_valid` stays high with a new command → `rsp_*` stable, `cmd_ready`=0 throughout, and the second command is accepted only after the handshake plus one IDLE cycle.
- Preload `ovf_count`=16'hFFFF and `txn_count`=16'hFFFF, then run an overflowing transaction → `ovf_count` stays 16'hFFFF and `txn_count` becomes 0.
- Assert `rst_n`=0 in WAIT → immediately `rsp_valid`=0, `cmd_ready`=1 and counters 0, and no response appears after release.
